// File: rtl/hnf_rxreq_lcrd_pkg.sv
// Shared types for the HN-F RXREQ link-layer receiver: request flit layout,
// the L-credit return opcode and the RX link state encoding.
package hnf_rxreq_lcrd_pkg;

    localparam int REQ_OPC_W = 7;
    localparam logic [REQ_OPC_W-1:0] REQ_OPC_LCRDRETURN = 7'h00;

    typedef struct packed {
        logic [REQ_OPC_W-1:0] opcode;
        logic [6:0]           srcid;
        logic [7:0]           txnid;
        logic [15:0]          addr;
    } reqflit_t;

    typedef enum logic [1:0] {
        LINK_STOP       = 2'd0,
        LINK_ACTIVATE   = 2'd1,
        LINK_RUN        = 2'd2,
        LINK_DEACTIVATE = 2'd3
    } link_state_e;

    function automatic logic is_lcrd_return(input reqflit_t f);
        return f.opcode == REQ_OPC_LCRDRETURN;
    endfunction

endpackage

// File: rtl/hnf_rxreq_lcrd_if.sv
// RXREQ channel plus the buffered request hand-off to the HN-F pipeline.
// slave = receiver view, master = requester / pipeline side.
interface hnf_rxreq_lcrd_if;
    import hnf_rxreq_lcrd_pkg::*;

    logic     rxlinkactivereq;
    logic     rxlinkactiveack;
    logic     rxreqflitpend;
    logic     rxreqflitv;
    reqflit_t rxreqflit;
    logic     rxreqlcrdv;
    logic     req_valid;
    reqflit_t req_flit;
    logic     req_ready;

    modport slave (
        input  rxlinkactivereq, rxreqflitpend, rxreqflitv, rxreqflit, req_ready,
        output rxlinkactiveack, rxreqlcrdv, req_valid, req_flit
    );

    modport master (
        output rxlinkactivereq, rxreqflitpend, rxreqflitv, rxreqflit, req_ready,
        input  rxlinkactiveack, rxreqlcrdv, req_valid, req_flit
    );

endinterface

// File: rtl/hnf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous active-low reset.
// Head entry is read combinationally, so data is visible the cycle after push.
module hnf_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Credit accounting upstream must make this unreachable.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_b) !(push_i && full_o));

endmodule

// File: rtl/hnf_rxreq_lcrd.sv
// HN-F RXREQ link-layer receiver: link activation, L-credit issue bounded by
// buffer space, request buffering and sticky protocol-error flags.
//   state      | meaning
//   STOP       | link down, ack low, no credits
//   ACTIVATE   | ack raised, one cycle before credits flow
//   RUN        | credits issued while space allows
//   DEACTIVATE | ack held, waiting for outstanding credits to drain
module hnf_rxreq_lcrd
    import hnf_rxreq_lcrd_pkg::*;
#(
    parameter  int NUM_LCRD   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    hnf_rxreq_lcrd_if.slave      rx,
    output logic [CNT_W-1:0]     lcrd_outstanding_o,
    output logic [1:0]           err_o
);

    localparam logic [CNT_W-1:0] NUM_LCRD_C = CNT_W'(NUM_LCRD);
    localparam logic [CNT_W:0]   SPACE_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam int               FLIT_W     = $bits(reqflit_t);

    link_state_e      state_q;
    logic             ack_q;
    logic             lcrdv_q;
    logic             flitpend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic [FLIT_W-1:0] fifo_rdata;
    logic              flit_ok, push, pop, grant;
    logic [CNT_W:0]    used;

    // cnt_q already includes a grant in the cycle its pulse is driven,
    // so no separate pending-grant term is needed in the space check.
    always_comb begin
        flit_ok = rx.rxreqflitv && (cnt_q != '0);
        push    = flit_ok && !is_lcrd_return(rx.rxreqflit);
        pop     = !fifo_empty && rx.req_ready;
        used    = {1'b0, cnt_q} + {1'b0, fifo_cnt};
        grant   = (state_q == LINK_RUN) && (used < SPACE_C) &&
                  (cnt_q < NUM_LCRD_C) && !fifo_full;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= LINK_STOP;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                LINK_STOP: begin
                    if (rx.rxlinkactivereq) begin
                        state_q <= LINK_ACTIVATE;
                        ack_q   <= 1'b1;
                    end
                end
                LINK_ACTIVATE: state_q <= LINK_RUN;
                LINK_RUN: begin
                    if (!rx.rxlinkactivereq) begin
                        state_q <= LINK_DEACTIVATE;
                    end
                end
                LINK_DEACTIVATE: begin
                    if (cnt_q == '0) begin
                        state_q <= LINK_STOP;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LINK_STOP;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lcrdv_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 2'b00;
            flitpend_q <= 1'b0;
        end else begin
            lcrdv_q    <= grant;
            cnt_q      <= cnt_q + CNT_W'(grant) - CNT_W'(flit_ok);
            flitpend_q <= rx.rxreqflitpend;
            err_q[0]   <= err_q[0] | (rx.rxreqflitv && (cnt_q == '0));
            err_q[1]   <= err_q[1] | (rx.rxreqflitv && !flitpend_q);
        end
    end

    hnf_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_b   (reset),
        .push_i  (push),
        .wdata_i (rx.rxreqflit),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign rx.rxlinkactiveack = ack_q;
    assign rx.rxreqlcrdv      = lcrdv_q;
    assign rx.req_valid       = !fifo_empty;
    assign rx.req_flit        = reqflit_t'(fifo_rdata);
    assign lcrd_outstanding_o = cnt_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_hnf_rxreq_lcrd.sv
// Directed bench for hnf_rxreq_lcrd: stimulus pushes expected buffered flits
// into a scoreboard queue, a negedge monitor pops and compares on each hand-off.
module tb_hnf_rxreq_lcrd;
    import hnf_rxreq_lcrd_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] lcrd_outstanding;
    logic [1:0] err;

    int checks = 0;
    int errors = 0;
    int grants_seen = 0;
    int g0;
    reqflit_t sb[$];
    reqflit_t mon_exp;
    reqflit_t fy;

    hnf_rxreq_lcrd_if ifc ();

    hnf_rxreq_lcrd #(.NUM_LCRD(4), .FIFO_DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .rx                 (ifc),
        .lcrd_outstanding_o (lcrd_outstanding),
        .err_o              (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic reqflit_t mk(input logic [6:0] opc, input logic [7:0] id);
        reqflit_t f;
        f.opcode = opc;
        f.srcid  = 7'h11;
        f.txnid  = id;
        f.addr   = {id, 8'hA5};
        return f;
    endfunction

    // flitpend one cycle ahead of flitv
    task automatic send_flit(input reqflit_t f, input logic exp_push);
        ifc.rxreqflitpend = 1'b1;
        tick(1);
        ifc.rxreqflitpend = 1'b0;
        ifc.rxreqflitv    = 1'b1;
        ifc.rxreqflit     = f;
        if (exp_push) sb.push_back(f);
        tick(1);
        ifc.rxreqflitv    = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && ifc.rxreqlcrdv === 1'b1) grants_seen++;
        if (reset === 1'b1 && ifc.req_valid === 1'b1 && ifc.req_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none at %0t", ifc.req_flit, $time);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop_flit", 64'(ifc.req_flit), 64'(mon_exp));
            end
        end
    end

    initial begin
        reset               = 1'b0;
        ifc.rxlinkactivereq = 1'b0;
        ifc.rxreqflitpend   = 1'b0;
        ifc.rxreqflitv      = 1'b0;
        ifc.rxreqflit       = '0;
        ifc.req_ready       = 1'b0;
        tick(2);
        chk("rst_ack",   64'(ifc.rxlinkactiveack), 64'd0);
        chk("rst_lcrdv", 64'(ifc.rxreqlcrdv), 64'd0);
        chk("rst_cnt",   64'(lcrd_outstanding), 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        chk("rst_valid", 64'(ifc.req_valid), 64'd0);
        reset = 1'b1;

        // bring-up: ack one cycle after req, then 4 back-to-back grants
        ifc.rxlinkactivereq = 1'b1;
        tick(1);
        chk("up_ack", 64'(ifc.rxlinkactiveack), 64'd1);
        tick(1);
        chk("up_lcrdv_run0", 64'(ifc.rxreqlcrdv), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("up_lcrdv", 64'(ifc.rxreqlcrdv), 64'd1);
            chk("up_cnt", 64'(lcrd_outstanding), 64'(i + 1));
        end
        tick(1);
        chk("up_lcrdv_done", 64'(ifc.rxreqlcrdv), 64'd0);
        chk("up_cnt_done", 64'(lcrd_outstanding), 64'd4);

        // flow: fill the FIFO with ready low, then drain in order
        g0 = grants_seen;
        for (int i = 0; i < 4; i++) send_flit(mk(7'h04, 8'(8'h01 + i)), 1'b1);
        chk("fill_cnt", 64'(lcrd_outstanding), 64'd0);
        chk("fill_valid", 64'(ifc.req_valid), 64'd1);
        chk("fill_head", 64'(ifc.req_flit), 64'(mk(7'h04, 8'h01)));
        tick(3);
        chk("fill_no_grant", 64'(grants_seen - g0), 64'd0);
        ifc.req_ready = 1'b1;
        tick(8);
        chk("drain_grants", 64'(grants_seen - g0), 64'd4);
        chk("drain_cnt", 64'(lcrd_outstanding), 64'd4);
        chk("drain_valid", 64'(ifc.req_valid), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);

        // steady stream: grant and consume in the same cycle hold the count
        ifc.rxreqflitpend = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            ifc.rxreqflitv = 1'b1;
            ifc.rxreqflit  = mk(7'h05, 8'(8'h20 + i));
            sb.push_back(mk(7'h05, 8'(8'h20 + i)));
            tick(1);
            if (i >= 2) begin
                chk("strm_cnt", 64'(lcrd_outstanding), 64'd2);
                chk("strm_lcrdv", 64'(ifc.rxreqlcrdv), 64'd1);
            end
        end
        ifc.rxreqflitv    = 1'b0;
        ifc.rxreqflitpend = 1'b0;
        tick(6);
        chk("strm_cnt_end", 64'(lcrd_outstanding), 64'd4);
        chk("strm_sb", 64'(sb.size()), 64'd0);

        // deactivate with 3 outstanding and one buffered flit
        ifc.req_ready = 1'b0;
        send_flit(mk(7'h04, 8'h40), 1'b1);
        chk("deact_cnt3", 64'(lcrd_outstanding), 64'd3);
        g0 = grants_seen;
        ifc.rxlinkactivereq = 1'b0;
        tick(1);
        chk("deact_ack_hold", 64'(ifc.rxlinkactiveack), 64'd1);
        for (int i = 0; i < 3; i++) send_flit(mk(REQ_OPC_LCRDRETURN, 8'(8'h30 + i)), 1'b0);
        chk("deact_cnt0", 64'(lcrd_outstanding), 64'd0);
        chk("deact_ack_still", 64'(ifc.rxlinkactiveack), 64'd1);
        tick(1);
        chk("deact_ack_low", 64'(ifc.rxlinkactiveack), 64'd0);
        chk("deact_no_grant", 64'(grants_seen - g0), 64'd0);
        chk("deact_valid", 64'(ifc.req_valid), 64'd1);
        ifc.req_ready = 1'b1;
        tick(2);
        chk("deact_drained", 64'(ifc.req_valid), 64'd0);
        chk("deact_sb", 64'(sb.size()), 64'd0);

        // flit without credit
        ifc.req_ready = 1'b0;
        send_flit(mk(7'h04, 8'h50), 1'b0);
        chk("err_nocred", 64'(err), 64'd1);
        chk("err_nocred_valid", 64'(ifc.req_valid), 64'd0);
        chk("err_nocred_cnt", 64'(lcrd_outstanding), 64'd0);

        // relink, then flitv without preceding flitpend
        ifc.rxlinkactivereq = 1'b1;
        tick(6);
        chk("relink_cnt", 64'(lcrd_outstanding), 64'd4);
        fy = mk(7'h06, 8'h60);
        ifc.rxreqflitv = 1'b1;
        ifc.rxreqflit  = fy;
        tick(1);
        ifc.rxreqflitv = 1'b0;
        chk("err_nopend", 64'(err), 64'd3);
        chk("err_nopend_cnt", 64'(lcrd_outstanding), 64'd3);
        chk("err_nopend_valid", 64'(ifc.req_valid), 64'd1);
        chk("err_nopend_head", 64'(ifc.req_flit), 64'(fy));
        send_flit(mk(7'h04, 8'h61), 1'b0);
        chk("pre_rst_cnt", 64'(lcrd_outstanding), 64'd2);
        chk("pre_rst_lcrdv", 64'(ifc.rxreqlcrdv), 64'd0);

        // reset mid-traffic discards buffered flits and credits
        reset = 1'b0;
        ifc.rxlinkactivereq = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("mrst_valid", 64'(ifc.req_valid), 64'd0);
        chk("mrst_ack",   64'(ifc.rxlinkactiveack), 64'd0);
        chk("mrst_cnt",   64'(lcrd_outstanding), 64'd0);
        chk("mrst_err",   64'(err), 64'd0);
        chk("mrst_lcrdv", 64'(ifc.rxreqlcrdv), 64'd0);
        ifc.req_ready = 1'b1;
        tick(3);
        chk("mrst_valid_after", 64'(ifc.req_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
